// File: rtl/register_file_mp_if.sv
// Bundled read/write bus of the multi-port register file.
// The master drives addresses and write requests; the slave is the register file.
interface register_file_mp_if #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5,
  parameter int NUM_RD_P     = 2
);
  logic [NUM_RD_P*ADDR_WIDTH_P-1:0] i_rd_addr;
  logic [NUM_RD_P*DATA_WIDTH_P-1:0] o_rd_data;
  logic                             i_wr_enable_a;
  logic [ADDR_WIDTH_P-1:0]          i_wr_addr_a;
  logic [DATA_WIDTH_P-1:0]          i_wr_data_a;
  logic                             i_wr_enable_b;
  logic [ADDR_WIDTH_P-1:0]          i_wr_addr_b;
  logic [DATA_WIDTH_P-1:0]          i_wr_data_b;
  logic                             o_ready;

  modport master (
    output i_rd_addr, i_wr_enable_a, i_wr_addr_a, i_wr_data_a,
           i_wr_enable_b, i_wr_addr_b, i_wr_data_b,
    input  o_rd_data, o_ready
  );

  modport slave (
    input  i_rd_addr, i_wr_enable_a, i_wr_addr_a, i_wr_data_a,
           i_wr_enable_b, i_wr_addr_b, i_wr_data_b,
    output o_rd_data, o_ready
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file: two write ports, NUM_RD_P read ports, optional
// hardwired zero entry and write bypass, and a post-reset clear sweep of every entry.
module register_file_mp #(
  parameter int DATA_WIDTH_P = 32,
  parameter int ADDR_WIDTH_P = 5,
  parameter int DEPTH_P      = 32,
  parameter int NUM_RD_P     = 2,
  parameter int READ_LAT_P   = 0,
  parameter int BYPASS_P     = 1,
  parameter int ZERO_REG_P   = 1
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);
  typedef enum logic {CLEAR, READY} state_e;

  // The pointer is one bit wider than an address so a full-depth sweep cannot wrap early.
  localparam logic [ADDR_WIDTH_P:0] LastPtr = (ADDR_WIDTH_P+1)'(DEPTH_P - 1);

  state_e                            state_q, state_d;
  logic [ADDR_WIDTH_P:0]             ptr_q, ptr_d;
  logic                              clearWe;
  logic                              weA, weB;
  logic [DATA_WIDTH_P-1:0]           mem_q [DEPTH_P];
  logic [NUM_RD_P*DATA_WIDTH_P-1:0]  rdData_d;

  function automatic logic liveAddr(input logic [ADDR_WIDTH_P-1:0] addr);
    logic ok;
    ok = ({1'b0, addr} <= LastPtr);
    if (ZERO_REG_P != 0 && addr == '0) ok = 1'b0;
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clearWe = 1'b0;
    case (state_q)
      CLEAR: begin
        clearWe = 1'b1;
        ptr_d   = ptr_q + (ADDR_WIDTH_P+1)'(1);
        if (ptr_q == LastPtr) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  assign weA = (state_q == READY) && bus.i_wr_enable_a && liveAddr(bus.i_wr_addr_a);
  assign weB = (state_q == READY) && bus.i_wr_enable_b && liveAddr(bus.i_wr_addr_b);

  // Port B is checked before A so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH_P; e++) begin
        if (clearWe && ptr_q == (ADDR_WIDTH_P+1)'(e)) mem_q[e] <= '0;
        else if (weB && bus.i_wr_addr_b == ADDR_WIDTH_P'(e)) mem_q[e] <= bus.i_wr_data_b;
        else if (weA && bus.i_wr_addr_a == ADDR_WIDTH_P'(e)) mem_q[e] <= bus.i_wr_data_a;
      end
    end
  end

  function automatic logic [DATA_WIDTH_P-1:0] readPort(input logic [ADDR_WIDTH_P-1:0] addr);
    logic [DATA_WIDTH_P-1:0] value;
    value = '0;
    if (state_q == READY && liveAddr(addr)) begin
      for (int e = 0; e < DEPTH_P; e++) begin
        if (addr == ADDR_WIDTH_P'(e)) value = mem_q[e];
      end
      if (BYPASS_P != 0) begin
        if (weA && addr == bus.i_wr_addr_a) value = bus.i_wr_data_a;
        if (weB && addr == bus.i_wr_addr_b) value = bus.i_wr_data_b;
      end
    end
    return value;
  endfunction

  always_comb begin
    rdData_d = '0;
    for (int k = 0; k < NUM_RD_P; k++) begin
      rdData_d[k*DATA_WIDTH_P +: DATA_WIDTH_P] =
        readPort(bus.i_rd_addr[k*ADDR_WIDTH_P +: ADDR_WIDTH_P]);
    end
  end

  generate
    if (READ_LAT_P != 0) begin : gRegRead
      logic [NUM_RD_P*DATA_WIDTH_P-1:0] rdData_q;
      always_ff @(posedge clk) begin
        if (reset) rdData_q <= '0;
        else       rdData_q <= rdData_d;
      end
      assign bus.o_rd_data = rdData_q;
    end else begin : gCombRead
      assign bus.o_rd_data = rdData_d;
    end
  endgenerate

  assign bus.o_ready = (state_q == READY);
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port successor to the single-write, two-read register file, used as the integer register file of the pipeline.
- NUM_RD_P read ports and two write ports (A, B).
- Optional hardwired-zero entry 0.
- Optional write-to-read bypass.
- Selectable combinational or registered reads.
- Hardware clear sequencer: zeroes every entry, one per cycle, after reset. No init file is used.

Parameters:
DATA_WIDTH_P, 32, bits per entry
ADDR_WIDTH_P, 5, address width
DEPTH_P, 32, number of entries; must be <= 2**ADDR_WIDTH_P
NUM_RD_P, 2, number of read ports (1..8)
READ_LAT_P, 0, 0 = combinational read, 1 = registered read
BYPASS_P, 1, 1 = read of an address written this cycle returns the new write data
ZERO_REG_P, 1, 1 = entry 0 always reads 0 and writes to it are dropped

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_rd_addr  input  NUM_RD_P*ADDR_WIDTH_P  packed read addresses; port k = bits [k*ADDR_WIDTH_P +: ADDR_WIDTH_P]
o_rd_data  output  NUM_RD_P*DATA_WIDTH_P  packed read data, same packing
i_wr_enable_a  input  1  write port A enable
i_wr_addr_a  input  ADDR_WIDTH_P  write port A address
i_wr_data_a  input  DATA_WIDTH_P  write port A data
i_wr_enable_b  input  1  write port B enable
i_wr_addr_b  input  ADDR_WIDTH_P  write port B address
i_wr_data_b  input  DATA_WIDTH_P  write port B data
o_ready  output  1  1 = clear sequence done; writes accepted

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- FSM states: CLEAR and READY.
- While reset = 1:
  - state <= CLEAR, clear pointer <= 0, o_ready <= 0.
  - Registered read outputs (READ_LAT_P = 1) <= 0.
  - No memory write occurs.
- CLEAR, with reset = 0:
  - Each cycle write 0 to memory[ptr], then ptr <= ptr + 1.
  - The cycle that writes ptr = DEPTH_P-1 moves the state to READY and sets o_ready <= 1.
  - Clear therefore takes exactly DEPTH_P cycles after reset deasserts.
  - All DEPTH_P entries are cleared, including the last one.
- During CLEAR:
  - i_wr_enable_a and i_wr_enable_b are ignored; the writes are dropped.
  - All read ports return 0.
- Reset asserted mid-clear or in READY: the next edge returns the block to CLEAR with ptr = 0, and the sweep restarts.
- Writes in READY: on a rising edge, memory[addr] <= data for each enabled port.
  - Same address on A and B: port B wins.
  - Address >= DEPTH_P: the write is dropped.
  - ZERO_REG_P = 1 and address = 0: the write is dropped.
- Reads: each read port is independent; any number of ports may use the same address.
  - READ_LAT_P = 0: o_rd_data is combinational from i_rd_addr in the same cycle.
  - READ_LAT_P = 1: the value is sampled at the edge and presented the next cycle.
  - Address >= DEPTH_P: reads 0.
  - ZERO_REG_P = 1 and address = 0: reads 0 regardless of BYPASS_P.
- Bypass, BYPASS_P = 1:
  - If a read address matches an enabled, accepted write this cycle, the read returns that write data. Port B has priority over port A.
  - READ_LAT_P = 0: the new data appears combinationally in the same cycle.
  - READ_LAT_P = 1: the registered output captures the new data.
- BYPASS_P = 0:
  - READ_LAT_P = 0 returns the old contents until the edge.
  - READ_LAT_P = 1 captures the old contents.
- Widths: data is stored and returned unmodified at DATA_WIDTH_P; there is no arithmetic. The clear pointer is ADDR_WIDTH_P+1 bits wide so that DEPTH_P = 2**ADDR_WIDTH_P does not wrap early.

Test Plan:
1. Clear sequence: pulse reset for 1 cycle, DEPTH_P = 32. o_ready rises exactly 32 cycles after reset falls. Reading all 32 addresses then returns 0, including address 31.
2. Writes during CLEAR: hold i_wr_enable_a = 1, addr 5, data 0xDEADBEEF throughout CLEAR. After o_ready, address 5 reads 0.
3. Dual-write conflict: in READY, A writes addr 7 = 0x11111111 and B writes addr 7 = 0x22222222 in the same cycle. Next cycle, addr 7 reads 0x22222222 on every read port.
4. Bypass with READ_LAT_P = 0, BYPASS_P = 1: write addr 3 = 0xA5A5A5A5 while read port 1 addresses 3. o_rd_data port 1 = 0xA5A5A5A5 in the same cycle. Repeat with BYPASS_P = 0: the read shows the old value 0 in that cycle.
5. Zero register: write addr 0 = 0xFFFFFFFF on port A. All read ports addressing 0 return 0, both in the write cycle (bypass suppressed) and afterwards.
6. Mid-clear reset with READ_LAT_P = 1: assert reset at clear cycle 10 of a READY→CLEAR sweep. o_ready stays 0 and the registered outputs become 0 at the next edge. o_ready rises 32 cycles after the second reset falls. A write of addr 9 = 0x12345678 in READY is read back one cycle after it is addressed.
